// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert one parity bit after the data (even, or odd with PARITY_ODD=1).
module uart_tx_param #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_DATA   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP   = BIT_W'(STOP_BITS - 1);

    if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_tx_param: parameter out of legal range");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
    logic par_q;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q;
    logic                 tx_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic [BIT_W-1:0]     bit_q;
    logic [CNT_W-1:0]     baud_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 accept;
    logic                 baud_zero;

    assign accept    = (state_q == IDLE) && ready_q && i_valid;
    assign baud_zero = (baud_q == '0);

    // Each bit boundary leaving START or DATA presents the next payload bit at shift_q[0].
    always_comb begin
        shift_d = shift_q;
        if (accept) begin
            shift_d = i_data;
        end else if ((state_q == START || state_q == DATA) && baud_zero) begin
            shift_d = shift_q >> 1;
        end
    end

    // Payload storage carries no reset; it is only meaningful once a frame is accepted.
    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        if (accept) begin
            par_q <= (^i_data) ^ PAR_ODD_BIT;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bit_q   <= '0;
            baud_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        baud_q  <= BAUD_RELOAD;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (baud_zero) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        baud_q  <= BAUD_RELOAD;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baud_zero) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                            bit_q <= '0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[0];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_zero) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                        baud_q  <= BAUD_RELOAD;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_zero) begin
                        if (bit_q == LAST_STOP) begin
                            // First IDLE cycle: ready and done together allow a back-to-back accept.
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            bit_q   <= '0;
                            baud_q  <= '0;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            baud_q <= BAUD_RELOAD;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: two instances (8N1 at CLK_DIV=4, 5-bit/2-stop at CLK_DIV=3),
// each frame checked bit by bit against a line-level model of the expected serial waveform.
module tb_uart_tx_param;

    localparam int DIV_A = 4, DB_A = 8, SB_A = 1, PO_A = 0;
    localparam int DIV_B = 3, DB_B = 5, SB_B = 2, PO_B = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PBIT = 1;
`else
    localparam int PBIT = 0;
`endif
    localparam int BOUND = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [DB_A-1:0] da = '0;
    logic [DB_B-1:0] db = '0;
    logic va = 1'b0, vb = 1'b0;
    logic rdy_a, tx_a, busy_a, done_a;
    logic rdy_b, tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc [2];

    typedef struct {
        logic [8:0] data;
        int         acc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.CLK_DIV(DIV_A), .DATA_BITS(DB_A), .STOP_BITS(SB_A), .PARITY_ODD(PO_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(da), .i_valid(va),
        .o_ready(rdy_a), .o_tx(tx_a), .o_busy(busy_a), .o_done(done_a));

    uart_tx_param #(.CLK_DIV(DIV_B), .DATA_BITS(DB_B), .STOP_BITS(SB_B), .PARITY_ODD(PO_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(db), .i_valid(vb),
        .o_ready(rdy_b), .o_tx(tx_b), .o_busy(busy_b), .o_done(done_b));

    function automatic int div_of(int w); return (w != 0) ? DIV_B : DIV_A; endfunction
    function automatic int db_of(int w);  return (w != 0) ? DB_B  : DB_A;  endfunction
    function automatic int sb_of(int w);  return (w != 0) ? SB_B  : SB_A;  endfunction
    function automatic int po_of(int w);  return (w != 0) ? PO_B  : PO_A;  endfunction
    function automatic logic tx_of(int w);   return (w != 0) ? tx_b   : tx_a;   endfunction
    function automatic logic rdy_of(int w);  return (w != 0) ? rdy_b  : rdy_a;  endfunction
    function automatic logic busy_of(int w); return (w != 0) ? busy_b : busy_a; endfunction
    function automatic logic done_of(int w); return (w != 0) ? done_b : done_a; endfunction
    function automatic int qsize(int w); return (w != 0) ? q_b.size() : q_a.size(); endfunction

    function automatic int frame_len(int w);
        return 1 + db_of(w) + PBIT + sb_of(w);
    endfunction

    // Line level of bit k of a frame: start 0, payload LSB first, parity, then stop 1s.
    function automatic logic frame_bit(int w, logic [8:0] d, int k);
        int nb = db_of(w);
        if (k == 0) return 1'b0;
        if (k <= nb) return d[k-1];
        if (PBIT == 1 && k == nb + 1) return (($countones(d) + po_of(w)) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_in(input int w, input logic [8:0] d, input logic v);
        if (w != 0) begin
            db = d[DB_B-1:0];
            vb = v;
        end else begin
            da = d[DB_A-1:0];
            va = v;
        end
    endtask

    task automatic send(input int w, input logic [8:0] d, input bit hold);
        int t = 0;
        exp_t e;
        @(posedge clk);
        #1;
        set_in(w, d, 1'b1);
        @(negedge clk);
        while (rdy_of(w) !== 1'b1 && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (t >= BOUND) begin
            chk($sformatf("accept_timeout_%0d", w), 32'(rdy_of(w)), 32'd1);
        end else begin
            e.data = d & 9'((1 << db_of(w)) - 1);
            e.acc  = cyc + 1;
            last_acc[w] = e.acc;
            if (w != 0) q_b.push_back(e);
            else        q_a.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) set_in(w, d, 1'b0);
    endtask

    task automatic wait_idle(input int w);
        int t = 0;
        @(negedge clk);
        while ((busy_of(w) !== 1'b0 || qsize(w) != 0) && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (t >= BOUND) chk($sformatf("idle_timeout_%0d", w), 32'(busy_of(w)), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic monitor(input int w);
        logic       prev = 1'b1;
        logic       abort;
        logic [2:0] got, want, s;
        exp_t       e;
        int         len, k, c;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                continue;
            end
            chk($sformatf("done_idle_%0d", w), 32'(done_of(w)), 32'd0);
            if (prev === 1'b1 && tx_of(w) === 1'b0) begin
                if (qsize(w) == 0) begin
                    chk($sformatf("unexpected_frame_%0d", w), 32'(qsize(w)), 32'd1);
                end else begin
                    e = (w != 0) ? q_b.pop_front() : q_a.pop_front();
                    chk($sformatf("start_time_%0d", w), 32'(cyc), 32'(e.acc));
                    len   = frame_len(w);
                    abort = 1'b0;
                    k     = 0;
                    while (k < len && !abort) begin
                        want = {frame_bit(w, e.data, k), 1'b1, 1'b0};
                        got  = want;
                        c    = 0;
                        while (c < div_of(w) && !abort) begin
                            if (k != 0 || c != 0) begin
                                @(negedge clk);
                                if (rst) abort = 1'b1;
                            end
                            if (!abort) begin
                                s = {tx_of(w), busy_of(w), rdy_of(w)};
                                if (s !== want && got === want) got = s;
                            end
                            c++;
                        end
                        if (!abort) chk($sformatf("frame%0d_d%0h_bit%0d_tx_busy_rdy", w, e.data, k), 32'(got), 32'(want));
                        k++;
                    end
                    if (!abort) begin
                        @(negedge clk);
                        if (!rst)
                            chk($sformatf("frame%0d_end_tx_busy_rdy_done", w),
                                32'({tx_of(w), busy_of(w), rdy_of(w), done_of(w)}), 32'b1011);
                    end
                end
            end
            prev = tx_of(w);
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  a1;
        bit  hold;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_tx_a", 32'(tx_a), 32'd1);
        repeat (2) @(negedge clk);
        chk("reset_tx_a",   32'(tx_a),   32'd1);
        chk("reset_rdy_a",  32'(rdy_a),  32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_done_a", 32'(done_a), 32'd0);
        chk("reset_tx_b",   32'(tx_b),   32'd1);
        chk("reset_rdy_b",  32'(rdy_b),  32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset_a", 32'(rdy_a), 32'd1);
        chk("ready_after_reset_b", 32'(rdy_b), 32'd1);

        send(0, 9'h08, 1'b0);
        wait_idle(0);
        send(0, 9'h38, 1'b0);
        wait_idle(0);

        // back-to-back with i_valid held high
        send(0, 9'h08, 1'b1);
        a1 = last_acc[0];
        send(0, 9'h38, 1'b0);
        chk("b2b_period", 32'(last_acc[0] - a1), 32'(frame_len(0) * DIV_A + 1));
        wait_idle(0);

        // valid pulsed and data changed mid-frame must be ignored
        send(0, 9'h0C3, 1'b0);
        repeat (10) @(negedge clk);
        chk("ready_mid_frame", 32'(rdy_a), 32'd0);
        set_in(0, 9'h05A, 1'b1);
        repeat (3) @(negedge clk);
        set_in(0, 9'h0FF, 1'b1);
        repeat (2) @(negedge clk);
        set_in(0, 9'h0FF, 1'b0);
        wait_idle(0);

        // reset during data bit 3
        send(0, 9'h0A5, 1'b0);
        repeat (18) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midframe_rst_tx",   32'(tx_a),   32'd1);
        chk("midframe_rst_busy", 32'(busy_a), 32'd0);
        chk("midframe_rst_rdy",  32'(rdy_a),  32'd0);
        chk("midframe_rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_midframe_rst", 32'(rdy_a), 32'd1);
        send(0, 9'h05A, 1'b0);
        wait_idle(0);

        for (int i = 0; i < 16; i++) begin
            hold = (i != 15) && ($urandom_range(0, 1) == 1);
            send(0, 9'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle(0);

        send(1, 9'h015, 1'b0);
        wait_idle(1);
        for (int i = 0; i < 10; i++) begin
            hold = (i != 9) && ($urandom_range(0, 1) == 1);
            send(1, 9'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle(1);

        chk("scoreboard_empty_a", 32'(q_a.size()), 32'd0);
        chk("scoreboard_empty_b", 32'(q_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 16, i_clk cycles per serial bit (legal range 2..65535).
REQ-002 SHALL provide parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL provide parameter STOP_BITS, default 1, stop bits per frame (legal values 1, 2).
REQ-004 SHALL provide parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd (used only when UART_TX_PARITY_EN is defined).
REQ-005 SHALL provide port i_clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL provide port i_rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide port i_data, input, DATA_BITS, frame payload, sampled only on handshake.
REQ-008 SHALL provide port i_valid, input, 1, payload-offered strobe.
REQ-009 SHALL provide port o_ready, output, 1, transmitter can accept a payload this cycle.
REQ-010 SHALL provide port o_tx, output, 1, serial line, idle high.
REQ-011 SHALL provide port o_busy, output, 1, high while a frame is on the line.
REQ-012 SHALL provide port o_done, output, 1, one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is entered only when UART_TX_PARITY_EN is defined.
REQ-014 SHALL accept a payload when i_valid=1 and o_ready=1 at a rising edge; i_data is latched into an internal shift register at that edge.
REQ-015 SHALL drive o_ready=1 only in IDLE; o_ready falls in the cycle after acceptance.
REQ-016 SHALL ignore i_valid and changes to i_data outside IDLE; no payload is queued or dropped silently in a way visible on o_tx.
REQ-017 SHALL transition IDLE->START on acceptance, START->DATA, DATA->PARITY (or STOP) after DATA_BITS bits, PARITY->STOP, STOP->IDLE after STOP_BITS bits.
REQ-018 SHALL hold every bit (start, data, parity, each stop) on o_tx for exactly CLK_DIV i_clk cycles, timed by a down-counter of width $clog2(CLK_DIV) reloaded to CLK_DIV-1 at each bit boundary.
REQ-019 SHALL drive start bit 0, data LSB first, stop bits 1, and o_tx=1 in IDLE.
REQ-020 SHALL register o_tx (no combinational path from i_data or i_valid to o_tx); the start bit appears the cycle after acceptance.
REQ-021 SHALL assert o_busy in every state except IDLE.
REQ-022 SHALL pulse o_done for exactly one cycle, the first IDLE cycle after the last stop bit.
REQ-023 SHALL support back-to-back frames: with i_valid held high, acceptance occurs in that first IDLE cycle, giving frame period (1+DATA_BITS+P+STOP_BITS)*CLK_DIV+1 cycles, P = 1 if parity compiled in, else 0.

Reset
REQ-024 SHALL, on i_rst=1, asynchronously force state IDLE, o_tx=1, o_ready=0, o_busy=0, o_done=0, bit counter and baud counter to 0.
REQ-025 SHALL drive o_ready=1 from the first rising edge after i_rst deasserts.
REQ-026 SHALL, on reset mid-frame, abandon the frame immediately with o_tx high; no o_done pulse is generated for the abandoned frame.

Configuration
REQ-027 SHALL honour macro UART_TX_PARITY_EN: defined -> one parity bit after data, value ^payload for PARITY_ODD=0 and ~^payload for PARITY_ODD=1; undefined -> no PARITY state, no parity logic, PARITY_ODD ignored.

Verification
REQ-028 SHALL cover: CLK_DIV=4, DATA_BITS=8, no parity, i_data=0x08 -> o_tx = 0,0,0,0,1,0,0,0,0,1, each bit 4 cycles, o_done at cycle 41 after acceptance.
REQ-029 SHALL cover: parity on, PARITY_ODD=0, i_data=0x38 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 11 bits.
REQ-030 SHALL cover: i_valid held high, payloads 0x08 then 0x38 -> second start bit begins exactly 41 cycles after first (CLK_DIV=4, no parity), o_ready high one cycle between.
REQ-031 SHALL cover: i_valid pulsed and i_data changed mid-frame -> o_tx bit sequence of first payload unchanged, second payload not transmitted.
REQ-032 SHALL cover: i_rst asserted during data bit 3 -> o_tx=1 same cycle, o_busy=0, no o_done, next frame transmits correctly.
REQ-033 SHALL cover: DATA_BITS=5, STOP_BITS=2, i_data=5'h15 -> 0,1,0,1,0,1,1,1 on o_tx, stop held 2*CLK_DIV cycles.
